// File: rtl/fetch_stage_ifid_if.sv
// Bundle between the IF stage and the rest of the pipeline: downstream control,
// instruction-memory preload port and the IF/ID register contents.
interface fetch_stage_ifid_if #(
    parameter int PC_WIDTH   = 64,
    parameter int IMEM_DEPTH = 64
);
    localparam int AW = $clog2(IMEM_DEPTH);

    // No valid/ready pair: stall is level back-pressure that freezes IF, branch_taken
    // overrides stall, and IF_ID_valid qualifies the IF/ID contents every cycle.
    logic                  stall;
    logic                  branch_taken;
    logic [PC_WIDTH-1:0]   branch_target;
    logic                  imem_we;
    logic [AW-1:0]         imem_waddr;
    logic [31:0]           imem_wdata;

    logic [PC_WIDTH-1:0]   PC;
    logic [31:0]           instruction;
    logic [PC_WIDTH-1:0]   IF_ID_PC;
    logic [31:0]           IF_ID_instruction;
    logic                  IF_ID_valid;
    logic                  halted;
    logic [31:0]           fetch_count;
    logic                  fsm_state;

    modport master (
        output stall, branch_taken, branch_target, imem_we, imem_waddr, imem_wdata,
        input  PC, instruction, IF_ID_PC, IF_ID_instruction, IF_ID_valid, halted,
               fetch_count, fsm_state
    );

    modport slave (
        input  stall, branch_taken, branch_target, imem_we, imem_waddr, imem_wdata,
        output PC, instruction, IF_ID_PC, IF_ID_instruction, IF_ID_valid, halted,
               fetch_count, fsm_state
    );
endinterface

// File: rtl/fetch_stage_ifid.sv
// IF stage: PC register, word-addressed instruction memory and IF/ID register.
// Fetch halts on an all-zero word or a PC outside the memory until a redirect.
module fetch_stage_ifid #(
    parameter int                 PC_WIDTH   = 64,
    parameter int                 IMEM_DEPTH = 64,
    parameter logic [PC_WIDTH-1:0] RESET_PC  = '0
) (
    input logic               clk,
    input logic               reset,
    fetch_stage_ifid_if.slave bus
);
    localparam int          AW  = $clog2(IMEM_DEPTH);
    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef enum logic {ST_RUN = 1'b0, ST_HALT = 1'b1} state_t;

    state_t              state_q, state_d;
    logic [PC_WIDTH-1:0] pc_q, pc_d;
    logic [PC_WIDTH-1:0] ifid_pc_q, ifid_pc_d;
    logic [31:0]         ifid_instr_q, ifid_instr_d;
    logic                ifid_valid_q, ifid_valid_d;
    logic [31:0]         fetch_count_q, fetch_count_d;

    logic [31:0]         imem [IMEM_DEPTH];
    logic [AW-1:0]       word_idx;
    logic                in_range;
    logic [31:0]         word;

    // Full PC is compared so high bits cannot alias back into the memory.
    assign word_idx = pc_q[2 +: AW];
    assign in_range = (pc_q >> 2) < PC_WIDTH'(IMEM_DEPTH);
    assign word     = in_range ? imem[word_idx] : NOP;

    always_ff @(posedge clk) begin
        if (bus.imem_we) begin
            imem[bus.imem_waddr] <= bus.imem_wdata;
        end
    end

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        ifid_pc_d     = ifid_pc_q;
        ifid_instr_d  = ifid_instr_q;
        ifid_valid_d  = ifid_valid_q;
        fetch_count_d = fetch_count_q;
        if (bus.branch_taken) begin
            pc_d         = bus.branch_target & ~PC_WIDTH'(3);
            ifid_instr_d = NOP;
            ifid_valid_d = 1'b0;
            state_d      = ST_RUN;
        end else if (!bus.stall) begin
            case (state_q)
                ST_RUN: begin
                    if (in_range && word != 32'h0) begin
                        ifid_pc_d     = pc_q;
                        ifid_instr_d  = word;
                        ifid_valid_d  = 1'b1;
                        pc_d          = pc_q + PC_WIDTH'(4);
                        fetch_count_d = fetch_count_q + 32'd1;
                    end else begin
                        state_d      = ST_HALT;
                        ifid_instr_d = NOP;
                        ifid_valid_d = 1'b0;
                    end
                end
                default: begin
                    ifid_instr_d = NOP;
                    ifid_valid_d = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= ST_RUN;
            pc_q          <= RESET_PC;
            ifid_pc_q     <= '0;
            ifid_instr_q  <= NOP;
            ifid_valid_q  <= 1'b0;
            fetch_count_q <= '0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            ifid_pc_q     <= ifid_pc_d;
            ifid_instr_q  <= ifid_instr_d;
            ifid_valid_q  <= ifid_valid_d;
            fetch_count_q <= fetch_count_d;
        end
    end

    assign bus.PC                = pc_q;
    assign bus.instruction       = word;
    assign bus.IF_ID_PC          = ifid_pc_q;
    assign bus.IF_ID_instruction = ifid_instr_q;
    assign bus.IF_ID_valid       = ifid_valid_q;
    assign bus.halted            = (state_q == ST_HALT);
    assign bus.fetch_count       = fetch_count_q;
    assign bus.fsm_state         = state_q;
endmodule

// File: tb/tb_fetch_stage_ifid.sv
// Bench for fetch_stage_ifid: directed scenarios plus randomized traffic checked
// against a cycle-level behavioural model of the fetch rules.
module tb_fetch_stage_ifid;
    localparam int          DEPTH = 16;
    localparam logic [31:0] NOP   = 32'h0000_0013;

    logic clk;
    logic reset;
    int   checks;
    int   errors;

    fetch_stage_ifid_if #(.PC_WIDTH(64), .IMEM_DEPTH(DEPTH)) bus ();

    fetch_stage_ifid #(.PC_WIDTH(64), .IMEM_DEPTH(DEPTH), .RESET_PC(64'h0)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model state
    logic [31:0] m_mem [DEPTH];
    logic [63:0] m_pc, m_ifid_pc;
    logic [31:0] m_ifid_ins, m_count;
    logic        m_valid, m_halted;

    function automatic logic [31:0] m_word();
        if (m_pc / 4 < 64'(DEPTH)) return m_mem[int'(m_pc / 4)];
        return NOP;
    endfunction

    task automatic model_tick();
        logic [31:0] w;
        w = m_word();
        if (reset) begin
            m_pc = 64'h0; m_ifid_pc = 64'h0; m_ifid_ins = NOP;
            m_valid = 1'b0; m_halted = 1'b0; m_count = 32'h0;
        end else if (bus.branch_taken) begin
            m_pc = bus.branch_target - (bus.branch_target % 4);
            m_ifid_ins = NOP; m_valid = 1'b0; m_halted = 1'b0;
        end else if (bus.stall) begin
            // everything holds
        end else if (m_halted) begin
            m_ifid_ins = NOP; m_valid = 1'b0;
        end else if (m_pc / 4 < 64'(DEPTH) && w != 32'h0) begin
            m_ifid_pc = m_pc; m_ifid_ins = w; m_valid = 1'b1;
            m_pc = m_pc + 4; m_count = m_count + 1;
        end else begin
            m_halted = 1'b1; m_ifid_ins = NOP; m_valid = 1'b0;
        end
        if (bus.imem_we) m_mem[int'(bus.imem_waddr)] = bus.imem_wdata;
    endtask

    task automatic tick();
        model_tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_idle();
        bus.stall = 1'b0; bus.branch_taken = 1'b0; bus.branch_target = '0;
        bus.imem_we = 1'b0; bus.imem_waddr = '0; bus.imem_wdata = '0;
    endtask

    task automatic preload(input int idx, input logic [31:0] data);
        bus.imem_we = 1'b1; bus.imem_waddr = 4'(idx); bus.imem_wdata = data;
        tick();
        bus.imem_we = 1'b0;
    endtask

    task automatic test_reset();
        drive_idle();
        reset = 1'b1;
        preload(0, 32'h0050_0093);
        preload(1, 32'h0030_0113);
        preload(2, 32'h0020_81B3);
        for (int i = 3; i < DEPTH; i++) preload(i, 32'h0);
        checks++; if (bus.PC !== 64'h0) begin errors++; $display("FAIL reset_pc: got %h expected %h", bus.PC, 64'h0); end
        checks++; if (bus.IF_ID_PC !== 64'h0) begin errors++; $display("FAIL reset_ifid_pc: got %h expected 0", bus.IF_ID_PC); end
        checks++; if (bus.IF_ID_instruction !== NOP) begin errors++; $display("FAIL reset_ifid_ins: got %h expected %h", bus.IF_ID_instruction, NOP); end
        checks++; if (bus.IF_ID_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", bus.IF_ID_valid); end
        checks++; if (bus.halted !== 1'b0) begin errors++; $display("FAIL reset_halted: got %b expected 0", bus.halted); end
        checks++; if (bus.fetch_count !== 32'h0) begin errors++; $display("FAIL reset_count: got %0d expected 0", bus.fetch_count); end
        reset = 1'b0;
    endtask

    task automatic test_program();
        logic [31:0] exp_ins [3];
        exp_ins[0] = 32'h0050_0093; exp_ins[1] = 32'h0030_0113; exp_ins[2] = 32'h0020_81B3;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (bus.IF_ID_PC !== 64'(4 * i) || bus.IF_ID_valid !== 1'b1)
                begin errors++; $display("FAIL prog_ifid_pc[%0d]: got %h/%b expected %h/1", i, bus.IF_ID_PC, bus.IF_ID_valid, 4 * i); end
            checks++; if (bus.IF_ID_instruction !== exp_ins[i])
                begin errors++; $display("FAIL prog_ifid_ins[%0d]: got %h expected %h", i, bus.IF_ID_instruction, exp_ins[i]); end
        end
        tick();
        checks++; if (bus.halted !== 1'b1) begin errors++; $display("FAIL prog_halted: got %b expected 1", bus.halted); end
        checks++; if (bus.fetch_count !== 32'd3) begin errors++; $display("FAIL prog_count: got %0d expected 3", bus.fetch_count); end
        checks++; if (bus.PC !== 64'hC) begin errors++; $display("FAIL prog_pc: got %h expected c", bus.PC); end
        checks++; if (bus.IF_ID_valid !== 1'b0) begin errors++; $display("FAIL prog_halt_valid: got %b expected 0", bus.IF_ID_valid); end
    endtask

    task automatic test_halt_restart();
        bus.branch_taken = 1'b1; bus.branch_target = 64'h0;
        tick();
        bus.branch_taken = 1'b0;
        checks++; if (bus.halted !== 1'b0 || bus.PC !== 64'h0)
            begin errors++; $display("FAIL restart_redirect: got halted=%b pc=%h expected 0/0", bus.halted, bus.PC); end
        checks++; if (bus.IF_ID_valid !== 1'b0) begin errors++; $display("FAIL restart_bubble: got %b expected 0", bus.IF_ID_valid); end
        tick();
        checks++; if (bus.IF_ID_valid !== 1'b1 || bus.IF_ID_PC !== 64'h0 || bus.IF_ID_instruction !== 32'h0050_0093)
            begin errors++; $display("FAIL restart_refetch: got %b %h %h expected 1 0 00500093", bus.IF_ID_valid, bus.IF_ID_PC, bus.IF_ID_instruction); end
        checks++; if (bus.fetch_count !== 32'd4) begin errors++; $display("FAIL restart_count: got %0d expected 4", bus.fetch_count); end
    endtask

    task automatic test_stall();
        tick();
        checks++; if (bus.PC !== 64'h8 || bus.IF_ID_PC !== 64'h4)
            begin errors++; $display("FAIL stall_setup: got pc=%h ifid=%h expected 8/4", bus.PC, bus.IF_ID_PC); end
        bus.stall = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tick();
            checks++; if (bus.PC !== 64'h8 || bus.IF_ID_PC !== 64'h4 || bus.fetch_count !== 32'd5 || bus.IF_ID_valid !== 1'b1)
                begin errors++; $display("FAIL stall_hold[%0d]: got pc=%h ifid=%h cnt=%0d v=%b expected 8/4/5/1", i, bus.PC, bus.IF_ID_PC, bus.fetch_count, bus.IF_ID_valid); end
        end
        bus.stall = 1'b0;
        tick();
        checks++; if (bus.IF_ID_PC !== 64'h8 || bus.PC !== 64'hC || bus.fetch_count !== 32'd6)
            begin errors++; $display("FAIL stall_resume: got ifid=%h pc=%h cnt=%0d expected 8/c/6", bus.IF_ID_PC, bus.PC, bus.fetch_count); end
    endtask

    task automatic test_branch_stall();
        bus.stall = 1'b1; bus.branch_taken = 1'b1; bus.branch_target = 64'h13;
        tick();
        drive_idle();
        checks++; if (bus.PC !== 64'h10) begin errors++; $display("FAIL brstall_pc: got %h expected 10", bus.PC); end
        checks++; if (bus.IF_ID_valid !== 1'b0 || bus.IF_ID_instruction !== NOP)
            begin errors++; $display("FAIL brstall_flush: got %b %h expected 0 %h", bus.IF_ID_valid, bus.IF_ID_instruction, NOP); end
        checks++; if (bus.fetch_count !== 32'd6) begin errors++; $display("FAIL brstall_count: got %0d expected 6", bus.fetch_count); end
    endtask

    task automatic test_out_of_range();
        logic [63:0] tgt [2];
        tgt[0] = 64'h40; tgt[1] = 64'h1_0000_0000;
        for (int i = 0; i < 2; i++) begin
            bus.branch_taken = 1'b1; bus.branch_target = tgt[i];
            tick();
            bus.branch_taken = 1'b0;
            checks++; if (bus.halted !== 1'b0 || bus.instruction !== NOP)
                begin errors++; $display("FAIL oor_redirect[%0d]: got halted=%b ins=%h expected 0/%h", i, bus.halted, bus.instruction, NOP); end
            tick();
            checks++; if (bus.halted !== 1'b1 || bus.PC !== tgt[i] || bus.IF_ID_valid !== 1'b0)
                begin errors++; $display("FAIL oor_halt[%0d]: got halted=%b pc=%h v=%b expected 1/%h/0", i, bus.halted, bus.PC, bus.IF_ID_valid, tgt[i]); end
        end
    endtask

    task automatic test_reset_mid();
        reset = 1'b1; tick(); reset = 1'b0;
        tick(); tick();
        checks++; if (bus.PC !== 64'h8 || bus.fetch_count !== 32'd2)
            begin errors++; $display("FAIL rmid_setup: got pc=%h cnt=%0d expected 8/2", bus.PC, bus.fetch_count); end
        reset = 1'b1; bus.stall = 1'b1; bus.branch_taken = 1'b1; bus.branch_target = 64'h24;
        tick();
        reset = 1'b0; drive_idle();
        checks++; if (bus.PC !== 64'h0 || bus.IF_ID_PC !== 64'h0 || bus.IF_ID_instruction !== NOP || bus.IF_ID_valid !== 1'b0 || bus.halted !== 1'b0 || bus.fetch_count !== 32'h0)
            begin errors++; $display("FAIL rmid_values: got pc=%h ifpc=%h ins=%h v=%b h=%b cnt=%0d expected reset values", bus.PC, bus.IF_ID_PC, bus.IF_ID_instruction, bus.IF_ID_valid, bus.halted, bus.fetch_count); end
        tick();
        checks++; if (bus.IF_ID_valid !== 1'b1 || bus.IF_ID_instruction !== 32'h0050_0093 || bus.fetch_count !== 32'd1)
            begin errors++; $display("FAIL rmid_restart: got v=%b ins=%h cnt=%0d expected 1/00500093/1", bus.IF_ID_valid, bus.IF_ID_instruction, bus.fetch_count); end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            reset = ($urandom_range(0, 59) == 0);
            bus.stall = ($urandom_range(0, 3) == 0);
            bus.branch_taken = ($urandom_range(0, 11) == 0);
            bus.branch_target = 64'($urandom_range(0, 'h4F));
            if ($urandom_range(0, 7) == 0) bus.branch_target[40] = 1'b1;
            bus.imem_we = ($urandom_range(0, 4) == 0);
            bus.imem_waddr = 4'($urandom_range(0, DEPTH - 1));
            bus.imem_wdata = ($urandom_range(0, 9) == 0) ? 32'h0 : $urandom;
            tick();
            checks++; if (bus.PC !== m_pc || bus.halted !== m_halted || bus.fetch_count !== m_count)
                begin errors++; $display("FAIL rand_state[%0d]: got pc=%h h=%b cnt=%0d expected %h/%b/%0d", i, bus.PC, bus.halted, bus.fetch_count, m_pc, m_halted, m_count); end
            checks++; if (bus.IF_ID_valid !== m_valid || bus.IF_ID_instruction !== m_ifid_ins || (m_valid && bus.IF_ID_PC !== m_ifid_pc))
                begin errors++; $display("FAIL rand_ifid[%0d]: got v=%b ins=%h pc=%h expected %b/%h/%h", i, bus.IF_ID_valid, bus.IF_ID_instruction, bus.IF_ID_PC, m_valid, m_ifid_ins, m_ifid_pc); end
            checks++; if (bus.instruction !== m_word())
                begin errors++; $display("FAIL rand_instruction[%0d]: got %h expected %h", i, bus.instruction, m_word()); end
        end
        drive_idle();
        reset = 1'b0;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        reset  = 1'b1;
        drive_idle();
        @(posedge clk);
        #1;
        test_reset();
        test_program();
        test_halt_restart();
        test_stall();
        test_branch_stall();
        test_out_of_range();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
